// File: rtl/fp8_dot_acc.sv
// fp8_dot_acc: sums N_TERMS truncated FP8 products (1 sign, 3 exp bias 3, 4 mant + hidden 1) into one element.
// Latency: 4 cycles per product (ACCEPT, ALIGN, ADD, NORM); the finished element appears in OUT after the last NORM.
// Backpressure: in_ready is high only in ACCEPT; a finished element holds in OUT (in_ready low) until out_ready.
// Ports: clk, rst_n (synchronous, active-low); in_valid/in_ready/in_data product stream in;
//        out_valid/out_ready/out_data finished dot-product element out.
module fp8_dot_acc #(
  parameter int N_TERMS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  typedef enum logic [2:0] {S_ACCEPT, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

  localparam logic [3:0] LAST_CNT = 4'(N_TERMS - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_b, r_acc, r_out_data, r_byp_res;
  logic [3:0] r_cnt;
  logic       r_byp, r_sgn, r_sub;
  logic [2:0] r_exp;
  logic [4:0] r_mbig, r_msml;
  logic [5:0] r_sum;

  // ALIGN: pick the larger magnitude by {exp, mant}, shift the smaller onto its exponent.
  logic       w_b_zero, w_acc_zero, w_acc_big;
  logic [7:0] w_big, w_sml;
  logic [2:0] w_ediff;
  logic [4:0] w_sml_sh;

  always_comb begin
    w_b_zero   = (r_b[6:0] == 7'd0);
    w_acc_zero = (r_acc[6:0] == 7'd0);
    w_acc_big  = (r_acc[6:0] >= r_b[6:0]);
    w_big      = w_acc_big ? r_acc : r_b;
    w_sml      = w_acc_big ? r_b : r_acc;
    w_ediff    = w_big[6:4] - w_sml[6:4];
    // Only 5 mantissa bits exist, so a gap of 5 or more shifts everything out.
    w_sml_sh   = (w_ediff >= 3'd5) ? 5'd0 : ({1'b1, w_sml[3:0]} >> w_ediff);
  end

  // ADD: magnitudes are already ordered, so the difference never goes negative.
  logic [5:0] w_sum;
  assign w_sum = r_sub ? ({1'b0, r_mbig} - {1'b0, r_msml})
                       : ({1'b0, r_mbig} + {1'b0, r_msml});

  // NORM: carry moves right by one, otherwise shift the leading one up to bit 4.
  logic [2:0]        w_lz;
  logic [3:0]        w_shl;
  logic signed [4:0] w_exp_n;
  logic [7:0]        w_res;

  always_comb begin
    casez (r_sum[4:0])
      5'b1????: w_lz = 3'd0;
      5'b01???: w_lz = 3'd1;
      5'b001??: w_lz = 3'd2;
      5'b0001?: w_lz = 3'd3;
      default:  w_lz = 3'd4;
    endcase
    // The leading one lands in the hidden bit, so only the low four bits survive.
    w_shl   = r_sum[3:0] << w_lz;
    w_exp_n = 5'sd0;
    w_res   = 8'h00;
    if (r_byp) begin
      w_res = r_byp_res;
    end else if (r_sum[5]) begin
      w_exp_n = $signed({2'b00, r_exp}) + 5'sd1;
      w_res   = (w_exp_n > 5'sd7) ? {r_sgn, 7'h7F} : {r_sgn, w_exp_n[2:0], r_sum[4:1]};
    end else if (r_sum[4:0] != 5'd0) begin
      w_exp_n = $signed({2'b00, r_exp}) - $signed({2'b00, w_lz});
      w_res   = (w_exp_n < 5'sd0) ? 8'h00 : {r_sgn, w_exp_n[2:0], w_shl};
    end
    // 1.0 x 2^-3 shares its encoding with zero, so it collapses to 0x00.
    if (w_res[6:0] == 7'd0) w_res = 8'h00;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_ACCEPT;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACCEPT: if (in_valid) w_state_nxt = S_ALIGN;
      S_ALIGN:  w_state_nxt = S_ADD;
      S_ADD:    w_state_nxt = S_NORM;
      S_NORM:   w_state_nxt = (r_cnt == LAST_CNT) ? S_OUT : S_ACCEPT;
      S_OUT:    if (out_ready) w_state_nxt = S_ACCEPT;
      default:  w_state_nxt = S_ACCEPT;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = rst_n && (r_state == S_ACCEPT);
    out_valid = (r_state == S_OUT);
    out_data  = r_out_data;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_b        <= 8'h00;
      r_acc      <= 8'h00;
      r_cnt      <= 4'd0;
      r_out_data <= 8'h00;
      r_byp      <= 1'b0;
      r_byp_res  <= 8'h00;
      r_sgn      <= 1'b0;
      r_sub      <= 1'b0;
      r_exp      <= 3'd0;
      r_mbig     <= 5'd0;
      r_msml     <= 5'd0;
      r_sum      <= 6'd0;
    end else begin
      case (r_state)
        S_ACCEPT: if (in_valid) r_b <= in_data;
        S_ALIGN: begin
          // Zero bypass still walks through ADD/NORM to keep latency constant.
          r_byp     <= w_b_zero | w_acc_zero;
          r_byp_res <= w_b_zero ? r_acc : r_b;
          r_sgn     <= w_big[7];
          r_sub     <= w_big[7] ^ w_sml[7];
          r_exp     <= w_big[6:4];
          r_mbig    <= {1'b1, w_big[3:0]};
          r_msml    <= w_sml_sh;
        end
        S_ADD: r_sum <= w_sum;
        S_NORM: begin
          r_acc <= w_res;
          if (r_cnt == LAST_CNT) r_out_data <= w_res;
          else                   r_cnt      <= r_cnt + 4'd1;
        end
        S_OUT: begin
          if (out_ready) begin
            r_acc <= 8'h00;
            r_cnt <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_dot_acc.sv
// tb_fp8_dot_acc: directed element sequences against an integer-valued FP8 model and hand-computed results.
// Timing of every product handshake is checked; a monitor checks every output cycle.
// out_ready is held low by default so each element's OUT phase is explicit.
module tb_fp8_dot_acc;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  fp8_dot_acc #(.N_TERMS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: a magnitude is (16 + mant) << exp, i.e. the value scaled by 2^7.
  function automatic int dec_mag(input logic [7:0] x);
    if (x[6:0] == 7'd0) return 0;
    return (16 + int'(x[3:0])) << x[6:4];
  endfunction

  function automatic logic [7:0] enc(input bit neg, input int mag);
    int e;
    logic [7:0] r;
    if (mag < 16) return 8'h00;
    if (mag >= (32 << 7)) return {neg, 7'h7F};
    e = 0;
    while ((mag >> e) >= 32) e++;
    r = {neg, 3'(e), 4'(mag >> e)};
    if (r[6:0] == 7'd0) r = 8'h00;
    return r;
  endfunction

  // Smaller operand is truncated to the larger operand's exponent grid before the signed add.
  function automatic logic [7:0] fp8_add(input logic [7:0] a, input logic [7:0] b);
    int ma, mb, mbig, msml, eb, t;
    bit sbig, ssml;
    ma = dec_mag(a);
    mb = dec_mag(b);
    if (mb == 0) return a;
    if (ma == 0) return b;
    if (ma >= mb) begin
      mbig = ma; sbig = a[7]; eb = int'(a[6:4]); msml = mb; ssml = b[7];
    end else begin
      mbig = mb; sbig = b[7]; eb = int'(b[6:4]); msml = ma; ssml = a[7];
    end
    msml = (msml >> eb) << eb;
    t = (sbig ? -mbig : mbig) + (ssml ? -msml : msml);
    if (t < 0) return enc(1'b1, -t);
    return enc(1'b0, t);
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] m_acc = 8'h00;
  int         m_cnt = 0;
  logic [7:0] held = 8'h00;
  bit         prev_ov = 1'b0;

  // Output monitor: every element that appears must be the next one the model predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rdy_vld_excl", 32'(in_ready & out_valid), 32'd0);
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
        else begin
          held = exp_q.pop_front();
          check("out_data_model", 32'(out_data), 32'(held));
        end
      end else if (out_valid) begin
        check("out_data_hold", 32'(out_data), 32'(held));
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  // Waits for in_ready, hands over one product and returns after one handshake edge.
  task automatic handshake(input logic [7:0] d, output bit ok);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = in_ready;
    if (!ok) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit use_lit, input logic [7:0] lit);
    bit ok, last;
    handshake(d, ok);
    if (ok) begin
      m_acc = fp8_add(m_acc, d);
      m_cnt++;
      last = (m_cnt == N);
      if (last) begin
        exp_q.push_back(m_acc);
        if (use_lit) check("model_pin", 32'(m_acc), 32'(lit));
        m_acc = 8'h00;
        m_cnt = 0;
      end
      for (int i = 1; i <= 3; i++) begin
        @(negedge clk);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        check("busy_out_valid", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      if (last) check("lat_out_valid", 32'(out_valid), 32'd1);
      else      check("lat_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  // Hands over one product, then pulses reset for the ADD cycle of that product.
  task automatic send_rst(input logic [7:0] d);
    bit ok;
    handshake(d, ok);
    if (ok) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_pulse_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_acc = 8'h00;
      m_cnt = 0;
      @(negedge clk);
      check("rst_pulse_after_in_ready", 32'(in_ready), 32'd1);
      check("rst_pulse_after_out_valid", 32'(out_valid), 32'd0);
    end
  endtask

  // Called in the first OUT cycle; stalls, then accepts the element.
  task automatic take(input int stall, input logic [7:0] lit);
    check("out_lit", 32'(out_data), 32'(lit));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_data", 32'(out_data), 32'(lit));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic elem(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input logic [7:0] lit, input int stall);
    send(a, 1'b0, 8'h00);
    send(b, 1'b0, 8'h00);
    send(c, 1'b0, 8'h00);
    send(d, 1'b1, lit);
    take(stall, lit);
  endtask

  initial begin
    // Reset with a product offered: it must not be accepted.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Hand-derived single steps that pin the model.
    check("pin_1p0_plus_1p0", 32'(fp8_add(8'h30, 8'h30)), 32'h40);
    check("pin_align_trunc", 32'(fp8_add(8'h40, 8'h10)), 32'h42);
    check("pin_cancel", 32'(fp8_add(8'h38, 8'hB8)), 32'h00);
    check("pin_saturate", 32'(fp8_add(8'h7F, 8'h7F)), 32'h7F);

    elem(8'h30, 8'h30, 8'h30, 8'h30, 8'h50, 0);   // 4 x 1.0 = 4.0
    elem(8'h40, 8'h10, 8'h00, 8'h80, 8'h42, 0);   // 2.0 + 0.25, both zeros bypassed
    elem(8'h38, 8'hB8, 8'h30, 8'h00, 8'h30, 0);   // 1.5 - 1.5 = 0, then 1.0
    elem(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 0);   // positive saturation
    elem(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);   // negative saturation
    elem(8'h30, 8'h30, 8'h30, 8'h30, 8'h50, 5);   // backpressure
    elem(8'h40, 8'h40, 8'h00, 8'h00, 8'h50, 0);   // acc cleared after OUT

    // Reset during ADD of the second term discards the partial sum.
    send(8'h7F, 1'b0, 8'h00);
    send_rst(8'h7F);
    elem(8'h30, 8'h30, 8'h30, 8'h30, 8'h50, 0);

    elem(8'h35, 8'hA2, 8'h4B, 8'h91, 8'h4E, 0);   // mixed signs, carry and shift-4 truncation
    elem(8'h12, 8'h91, 8'h03, 8'h83, 8'h00, 0);   // exponent underflow flush
    elem(8'h18, 8'h90, 8'h30, 8'hB0, 8'h00, 1);   // 1.0 x 2^-3 collapses to zero

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: run still active at t=%0t, limit 100000", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
